// File: rtl/neuron_accumulator.sv
// Streaming signed accumulator for one neuron. It sums a burst of signed
// products into a pre-activation value. Saturating or wrapping arithmetic
// is chosen by the SAT parameter. A length guard ends any burst that
// reaches MAX_LEN beats. Valid/ready handshakes are used on both sides.
module neuron_accumulator #(
  parameter int IN_W    = 19,
  parameter int OUT_W   = 24,
  parameter int MAX_LEN = 784,
  parameter int CNT_W   = 10,
  parameter int SAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_ovf,
  output logic                    out_len_err,
  output logic [CNT_W-1:0]        out_count
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        LEN_LIM = CNT_W'(MAX_LEN);

  // The guard bit disagrees with the sign bit only when the true sum left
  // the OUT_W range, so both arithmetic modes share one overflow test.
  function automatic logic sum_ovf(input logic signed [OUT_W:0] s);
    return s[OUT_W] ^ s[OUT_W-1];
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [OUT_W:0] s);
    if (sum_ovf(s)) return s[OUT_W] ? ACC_MIN : ACC_MAX;
    return $signed(s[OUT_W-1:0]);
  endfunction

  function automatic logic signed [OUT_W-1:0] wrap(input logic signed [OUT_W:0] s);
    return $signed(s[OUT_W-1:0]);
  endfunction

  state_t                  state_q, state_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;
  logic                    out_len_err_q, out_len_err_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;

  logic signed [OUT_W:0]   sum_p0;
  logic signed [OUT_W-1:0] acc_nxt_p0;
  logic [CNT_W-1:0]        cnt_inc_p0;
  logic                    ovf_nxt_p0;
  logic                    at_limit_p0;

  // Next accumulator value for the beat currently on in_data.
  always_comb begin
    sum_p0      = {acc_q[OUT_W-1], acc_q} + {{(OUT_W+1-IN_W){in_data[IN_W-1]}}, in_data};
    acc_nxt_p0  = (SAT != 0) ? saturate(sum_p0) : wrap(sum_p0);
    ovf_nxt_p0  = ovf_q | sum_ovf(sum_p0);
    cnt_inc_p0  = cnt_q + CNT_W'(1);
    at_limit_p0 = (cnt_inc_p0 == LEN_LIM);
  end

  // Burst control: accumulate in ACC, present the result in HOLD until it is taken.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ovf_d     = out_ovf_q;
    out_len_err_d = out_len_err_q;
    out_count_d   = out_count_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = acc_nxt_p0;
          cnt_d = cnt_inc_p0;
          ovf_d = ovf_nxt_p0;
          if (in_last || at_limit_p0) begin
            state_d       = HOLD;
            out_valid_d   = 1'b1;
            out_data_d    = acc_nxt_p0;
            out_count_d   = cnt_inc_p0;
            out_ovf_d     = ovf_nxt_p0;
            out_len_err_d = !in_last;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACC;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and result registers. Reset clears everything, including any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACC;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_ovf_q     <= 1'b0;
      out_len_err_q <= 1'b0;
      out_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ovf_q     <= out_ovf_d;
      out_len_err_q <= out_len_err_d;
      out_count_q   <= out_count_d;
    end
  end

  assign in_ready    = (state_q == ACC);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;
  assign out_len_err = out_len_err_q;
  assign out_count   = out_count_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator. Two instances share the same stimulus:
// u_sat uses saturating arithmetic and u_wrap uses wrapping arithmetic.
module tb_neuron_accumulator;

  localparam int IN_W = 19, OUT_W = 24, MAX_LEN = 784, CNT_W = 10;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic signed [IN_W-1:0] in_data;

  logic                    in_ready, out_valid, out_ovf, out_len_err;
  logic signed [OUT_W-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    in_ready_w, out_valid_w, out_ovf_w, out_len_err_w;
  logic signed [OUT_W-1:0] out_data_w;
  logic [CNT_W-1:0]        out_count_w;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_len_err(out_len_err), .out_count(out_count));

  neuron_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .out_len_err(out_len_err_w), .out_count(out_count_w));

  typedef struct {
    int n; int nhead; int h0; int h1; int h2; int rep; bit has_tail; int tail;
    bit last; bit gaps;
    int e_sat; bit o_sat; int e_wrap; bit o_wrap; int e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input int v, input bit last);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v[IN_W-1:0];
    in_last  = last;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL beat_accept: in_ready got 0, expected 1");
    end
    @(posedge clk);
  endtask

  task automatic check_result(input string tag, input int e_sat, input bit o_sat,
                              input int e_wrap, input bit o_wrap, input int e_cnt, input bit e_len);
    check({tag, " sat valid"},   longint'(out_valid), 1);
    check({tag, " sat data"},    longint'(out_data), longint'(e_sat));
    check({tag, " sat ovf"},     longint'(out_ovf), longint'(o_sat));
    check({tag, " sat count"},   longint'(out_count), longint'(e_cnt));
    check({tag, " sat len_err"}, longint'(out_len_err), longint'(e_len));
    check({tag, " wrap valid"},  longint'(out_valid_w), 1);
    check({tag, " wrap data"},   longint'(out_data_w), longint'(e_wrap));
    check({tag, " wrap ovf"},    longint'(out_ovf_w), longint'(o_wrap));
    check({tag, " wrap count"},  longint'(out_count_w), longint'(e_cnt));
    check({tag, " wrap len_err"}, longint'(out_len_err_w), longint'(e_len));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        n  nh  h0       h1   h2  rep      tail? tail     last gaps e_sat     o  e_wrap    o  cnt
    vecs[0] = '{3,  3, 100,     -30, 5,  0,       0, 0,       1, 1, 75,       0, 75,       0, 3};
    vecs[1] = '{40, 0, 0,       0,   0,  262143,  0, 0,       1, 0, 8388607,  1, -6291496, 1, 40};
    vecs[2] = '{40, 0, 0,       0,   0,  -262144, 0, 0,       1, 0, -8388608, 1, 6291456,  1, 40};
    vecs[3] = '{33, 0, 0,       0,   0,  262143,  0, 0,       1, 0, 8388607,  1, -8126497, 1, 33};
    vecs[4] = '{33, 1, 31,      0,   0,  262143,  0, 0,       1, 0, 8388607,  0, 8388607,  0, 33};
    vecs[5] = '{33, 1, 32,      0,   0,  262143,  0, 0,       1, 0, 8388607,  1, -8388608, 1, 33};
    vecs[6] = '{32, 0, 0,       0,   0,  -262144, 0, 0,       1, 0, -8388608, 0, -8388608, 0, 32};
    vecs[7] = '{34, 1, -262144, 0,   0,  262143,  0, 0,       1, 0, 8388575,  0, 8388575,  0, 34};
    vecs[8] = '{34, 0, 0,       0,   0,  262143,  1, -262144, 1, 0, 8126463,  1, 8388575,  1, 34};
    vecs[9] = '{1,  1, -262144, 0,   0,  0,       0, 0,       1, 0, -262144,  0, -262144,  0, 1};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", longint'(out_valid), 0);
    check("reset in_ready",  longint'(in_ready), 1);
    check("reset out_data",  longint'(out_data), 0);
    check("reset out_count", longint'(out_count), 0);
    check("reset out_ovf",   longint'(out_ovf), 0);
    check("reset len_err",   longint'(out_len_err), 0);

    // Table-driven bursts with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < vecs[i].n; b++) begin
        int v;
        if (b < vecs[i].nhead) v = (b == 0) ? vecs[i].h0 : (b == 1) ? vecs[i].h1 : vecs[i].h2;
        else if (vecs[i].has_tail && b == vecs[i].n - 1) v = vecs[i].tail;
        else v = vecs[i].rep;
        beat(v, vecs[i].last && (b == vecs[i].n - 1));
        if (vecs[i].gaps && b < vecs[i].n - 1) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_last  = 1'b1;
          @(posedge clk);
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_result($sformatf("v%0d", i), vecs[i].e_sat, vecs[i].o_sat,
                   vecs[i].e_wrap, vecs[i].o_wrap, vecs[i].e_cnt, 1'b0);
    end

    // The result is handed off with out_ready high, so out_valid drops on the next edge.
    @(negedge clk);
    check("handoff out_valid low", longint'(out_valid), 0);
    check("handoff in_ready high", longint'(in_ready), 1);

    // Backpressure: the result must stay put and offered beats must be refused.
    out_ready = 1'b0;
    beat(100, 1'b0);
    beat(-30, 1'b0);
    beat(5, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 19'sd999; in_last = 1'b1;
    check_result("bp", 75, 0, 75, 0, 3, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d out_valid", c), longint'(out_valid), 1);
      check($sformatf("bp%0d out_data", c),  longint'(out_data), 75);
      check($sformatf("bp%0d in_ready", c),  longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_data   = -19'sd7;
    @(negedge clk);
    check("bp release out_valid", longint'(out_valid), 0);
    check("bp release in_ready",  longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_result("bp next", -7, 0, -7, 0, 1, 1'b0);

    // Length guard: 784 beats with no in_last. Beat 785 must wait until the handoff.
    @(negedge clk);
    out_ready = 1'b0;
    for (int b = 0; b < MAX_LEN; b++) beat(1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 19'sd5; in_last = 1'b1;
    check_result("len", 784, 0, 784, 0, 784, 1'b1);
    repeat (2) @(negedge clk);
    check("len hold in_ready", longint'(in_ready), 0);
    check("len hold count",    longint'(out_count), 784);
    out_ready = 1'b1;
    @(negedge clk);
    check("len handoff out_valid", longint'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_result("len next", 5, 0, 5, 0, 1, 1'b0);

    // Reset mid-burst: the partial sum is discarded and no result appears for it.
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      beat(10, 1'b0);
      #1;
      check($sformatf("abort b%0d out_valid", b), longint'(out_valid), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out_valid", longint'(out_valid), 0);
    check("abort in_ready",  longint'(in_ready), 1);
    check("abort out_count", longint'(out_count), 0);
    beat(3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_result("abort next", 3, 0, 3, 0, 1, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
